// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter: FSM encoding, frame geometry
// and the default command nibble.
package dac_spi_tx_pkg;

   localparam int unsigned FRAME_W = 16;
   localparam logic [3:0]  DAC_CMD_DEFAULT = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] cmd,
                                                     input logic [7:0] code);
      return {cmd, code, 4'b0000};
   endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Request/status and SPI pin bundle between the ramp controller and the DAC transmitter.
interface dac_spi_tx_if;
   logic       spi_start;
   logic [7:0] voltage;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_cs_n;
   logic       busy;
   logic       done;

   modport master (
      output spi_start, voltage,
      input  spi_sclk, spi_mosi, spi_cs_n, busy, done
   );

   modport slave (
      input  spi_start, voltage,
      output spi_sclk, spi_mosi, spi_cs_n, busy, done
   );
endinterface

// File: rtl/dac_spi_tx_sclk_divider.sv
// SCLK half-period tick generator: down-counter reloaded with CLK_DIV-1,
// tick on terminal count while enabled.
module sclk_divider #(
   parameter int unsigned CLK_DIV = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (clear) begin
         cnt_q <= RELOAD;
      end else if (enable) begin
         cnt_q <= (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
      end
   end

   assign tick = enable && !clear && (cnt_q == 8'd0);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 16-bit DAC frame {cmd, code, 4'b0} with a
// one-deep pending request so back-to-back frames keep only the CS gap between them.
//
// state | meaning
// IDLE  | waiting for a start edge, CS high
// SETUP | CS low, SCLK low, MSB on MOSI for one half-period
// SHIFT | 16 SCLK periods, MOSI advances on falling edges
// HOLD  | CS low after the last falling edge for one half-period
// GAP   | CS high for CS_GAP cycles, busy still asserted
module dac_spi_tx
   import dac_spi_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV = 5,
   parameter int unsigned CS_GAP  = 4,
   parameter logic [3:0]  DAC_CMD = DAC_CMD_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   dac_spi_tx_if.slave   bus
);

   localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   shift_q, shift_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           gap_cnt_q, gap_cnt_d;
   logic                 sclk_q, sclk_d;
   logic                 done_q, done_d;
   logic                 pend_q, pend_d;
   logic [7:0]           pend_volt_q, pend_volt_d;
   logic                 start_q;
   logic                 armed_q;
   logic                 start_edge;
   logic                 div_en;
   logic                 div_clr;
   logic                 tick;

   // armed_q blocks a start level that was already high when reset released
   assign start_edge = bus.spi_start && !start_q && armed_q;

   assign div_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign div_clr = !div_en;

   sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (div_en),
      .clear  (div_clr),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= 5'd0;
         gap_cnt_q   <= 8'd0;
         sclk_q      <= 1'b0;
         done_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_volt_q <= 8'd0;
         start_q     <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sclk_q      <= sclk_d;
         done_q      <= done_d;
         pend_q      <= pend_d;
         pend_volt_q <= pend_volt_d;
         start_q     <= bus.spi_start;
         armed_q     <= armed_q || !bus.spi_start;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sclk_d      = 1'b0;
      done_d      = 1'b0;
      pend_d      = pend_q;
      pend_volt_d = pend_volt_q;

      if (start_edge && (state_q != ST_IDLE)) begin
         pend_d      = 1'b1;
         pend_volt_d = bus.voltage;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d   = ST_SETUP;
               shift_d   = make_frame(DAC_CMD, bus.voltage);
               bit_cnt_d = 5'd0;
            end
         end
         ST_SETUP: begin
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sclk_d = sclk_q;
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 5'd15) begin
                     state_d = ST_HOLD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d   = ST_GAP;
               done_d    = 1'b1;
               gap_cnt_d = GAP_RELOAD;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               // a fresh edge on the last gap cycle is newer than anything pending
               if (start_edge) begin
                  state_d   = ST_SETUP;
                  shift_d   = make_frame(DAC_CMD, bus.voltage);
                  bit_cnt_d = 5'd0;
                  pend_d    = 1'b0;
               end else if (pend_q) begin
                  state_d   = ST_SETUP;
                  shift_d   = make_frame(DAC_CMD, pend_volt_q);
                  bit_cnt_d = 5'd0;
                  pend_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.spi_sclk = sclk_q;
   assign bus.spi_mosi = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ? shift_q[FRAME_W-1] : 1'b0;
   assign bus.spi_cs_n = !div_en;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default instance plus a CLK_DIV=2/CS_GAP=1 instance,
// with a negedge monitor reconstructing frames and timing from the pins.
module tb_dac_spi_tx;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dac_spi_tx_if bus_a ();
   dac_spi_tx_if bus_b ();

   dac_spi_tx u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   dac_spi_tx #(.CLK_DIV(2), .CS_GAP(1)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   logic [1:0] m_sclk, m_mosi, m_cs, m_busy, m_done;
   assign m_sclk = {bus_b.spi_sclk, bus_a.spi_sclk};
   assign m_mosi = {bus_b.spi_mosi, bus_a.spi_mosi};
   assign m_cs   = {bus_b.spi_cs_n, bus_a.spi_cs_n};
   assign m_busy = {bus_b.busy,     bus_a.busy};
   assign m_done = {bus_b.done,     bus_a.done};

   int n_pass = 0;
   int n_total = 0;

   int cs_low_run [2], last_cs_low [2], cs_high_run [2], last_cs_high [2];
   int busy_run [2], last_busy [2], period_cnt [2], last_period [2];
   int nbits [2], last_nbits [2], frames [2], done_cnt [2], done_bad [2];
   int rises [2], unstable [2];
   logic [15:0] sr [2], last_frame [2];
   logic p_sclk [2], p_mosi [2], p_cs [2], p_busy [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         last_cs_low[d] = 0; last_cs_high[d] = 0; last_busy[d] = 0; last_period[d] = 0;
         last_nbits[d] = 0; frames[d] = 0; done_cnt[d] = 0; done_bad[d] = 0;
         rises[d] = 0; unstable[d] = 0; last_frame[d] = '0;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            p_sclk[d] = 1'b0; p_mosi[d] = 1'b0; p_cs[d] = 1'b1; p_busy[d] = 1'b0;
            cs_low_run[d] = 0; cs_high_run[d] = 0; busy_run[d] = 0;
            period_cnt[d] = 0; nbits[d] = 0; sr[d] = '0;
         end else begin
            if (!m_cs[d]) begin
               if (p_cs[d]) begin
                  last_cs_high[d] = cs_high_run[d];
                  cs_low_run[d] = 0; sr[d] = '0; nbits[d] = 0;
               end
               cs_low_run[d]++;
            end else begin
               if (!p_cs[d]) begin
                  last_cs_low[d] = cs_low_run[d];
                  last_frame[d]  = sr[d];
                  last_nbits[d]  = nbits[d];
                  frames[d]++;
                  cs_high_run[d] = 0;
               end
               cs_high_run[d]++;
            end
            period_cnt[d]++;
            if (m_sclk[d] && !p_sclk[d]) begin
               rises[d]++;
               sr[d] = {sr[d][14:0], m_mosi[d]};
               nbits[d]++;
               if (m_mosi[d] != p_mosi[d]) unstable[d]++;
               last_period[d] = period_cnt[d];
               period_cnt[d] = 0;
            end
            if (m_done[d]) begin
               done_cnt[d]++;
               if (!(m_cs[d] && !p_cs[d])) done_bad[d]++;
            end
            if (m_busy[d]) busy_run[d]++;
            else if (p_busy[d]) begin
               last_busy[d] = busy_run[d];
               busy_run[d] = 0;
            end
            p_sclk[d] = m_sclk[d]; p_mosi[d] = m_mosi[d];
            p_cs[d]   = m_cs[d];   p_busy[d] = m_busy[d];
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                    name, actual, actual, expected, expected);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_start(input int d, input logic s);
      if (d == 0) bus_a.spi_start = s;
      else        bus_b.spi_start = s;
   endtask

   task automatic set_volt(input int d, input logic [7:0] v);
      if (d == 0) bus_a.voltage = v;
      else        bus_b.voltage = v;
   endtask

   task automatic wait_frames(input int d, input int target, input int budget, input string name);
      int n = 0;
      while (frames[d] < target && n < budget) begin
         step();
         n++;
      end
      check(name, frames[d], target);
   endtask

   task automatic wait_not_busy(input int d, input int budget, input string name);
      int n = 0;
      while (m_busy[d] && n < budget) begin
         step();
         n++;
      end
      check(name, int'(m_busy[d]), 0);
   endtask

   typedef struct {
      logic [7:0]  volt;
      int          hold;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [5];
   int f0, dn0, r0;

   initial begin
      vecs[0] = '{volt: 8'hA5, hold: 1, exp: 16'h3A50};
      vecs[1] = '{volt: 8'h5A, hold: 4, exp: 16'h35A0};
      vecs[2] = '{volt: 8'hFF, hold: 2, exp: 16'h3FF0};
      vecs[3] = '{volt: 8'h00, hold: 1, exp: 16'h3000};
      vecs[4] = '{volt: 8'h01, hold: 4, exp: 16'h3010};

      bus_a.spi_start = 1'b0; bus_a.voltage = 8'h00;
      bus_b.spi_start = 1'b0; bus_b.voltage = 8'h00;
      repeat (3) step();
      check("reset cs_n",  int'(bus_a.spi_cs_n), 1);
      check("reset sclk",  int'(bus_a.spi_sclk), 0);
      check("reset mosi",  int'(bus_a.spi_mosi), 0);
      check("reset busy",  int'(bus_a.busy), 0);
      check("reset done",  int'(bus_a.done), 0);

      // start already high at reset release must not fire
      set_start(0, 1'b1);
      step();
      reset = 1'b0;
      repeat (20) step();
      check("held start at release busy", int'(bus_a.busy), 0);
      check("held start at release frames", frames[0], 0);
      set_start(0, 1'b0);
      repeat (3) step();

      for (int i = 0; i < 5; i++) begin
         f0 = frames[0]; dn0 = done_cnt[0];
         set_volt(0, vecs[i].volt);
         set_start(0, 1'b1);
         step();
         check("cs_n low after accept", int'(bus_a.spi_cs_n), 0);
         for (int h = 1; h < vecs[i].hold; h++) step();
         set_start(0, 1'b0);
         wait_frames(0, f0 + 1, 400, "frame complete");
         check("frame bits", int'(last_frame[0]), int'(vecs[i].exp));
         check("cs_n low cycles", last_cs_low[0], 170);
         check("sclk rises per frame", last_nbits[0], 16);
         wait_not_busy(0, 50, "busy release");
         check("busy cycles", last_busy[0], 174);
         repeat (5) step();
         check("frames per start", frames[0], f0 + 1);
         check("done pulses per frame", done_cnt[0], dn0 + 1);
      end

      // two edges mid-frame: the later one wins and follows after the gap
      f0 = frames[0];
      set_volt(0, 8'h10); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      repeat (20) step();
      set_volt(0, 8'h01); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      repeat (10) step();
      set_volt(0, 8'h02); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      wait_frames(0, f0 + 1, 400, "b2b first frame");
      check("b2b first frame bits", int'(last_frame[0]), 16'h3100);
      wait_frames(0, f0 + 2, 400, "b2b second frame");
      check("b2b second frame bits", int'(last_frame[0]), 16'h3020);
      check("b2b cs_n high gap", last_cs_high[0], 4);
      wait_not_busy(0, 50, "b2b busy release");
      check("b2b busy continuous", last_busy[0], 348);
      repeat (5) step();
      check("b2b frame count", frames[0], f0 + 2);

      // edge landing on the final gap cycle
      f0 = frames[0];
      set_volt(0, 8'h44); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      repeat (173) step();
      check("last gap cycle busy", int'(bus_a.busy), 1);
      check("last gap cycle cs_n", int'(bus_a.spi_cs_n), 1);
      set_volt(0, 8'h77); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      wait_frames(0, f0 + 2, 400, "gap-edge frames");
      check("gap-edge frame bits", int'(last_frame[0]), 16'h3770);
      check("gap-edge cs_n high gap", last_cs_high[0], 4);
      wait_not_busy(0, 50, "gap-edge busy release");
      check("gap-edge busy continuous", last_busy[0], 348);

      // voltage change after capture
      f0 = frames[0];
      set_volt(0, 8'h00); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      repeat (50) step();
      set_volt(0, 8'hFF);
      wait_frames(0, f0 + 1, 400, "capture frame");
      check("capture frame bits", int'(last_frame[0]), 16'h3000);
      wait_not_busy(0, 50, "capture busy release");

      // reset in the middle of bit 7
      f0 = frames[0];
      set_volt(0, 8'hA5); set_start(0, 1'b1); step(); set_start(0, 1'b0);
      begin
         int n = 0;
         while (nbits[0] < 7 && n < 300) begin step(); n++; end
      end
      check("reached bit 7", nbits[0], 7);
      dn0 = done_cnt[0]; r0 = rises[0];
      reset = 1'b1;
      #1;
      check("abort cs_n",  int'(bus_a.spi_cs_n), 1);
      check("abort sclk",  int'(bus_a.spi_sclk), 0);
      check("abort mosi",  int'(bus_a.spi_mosi), 0);
      check("abort busy",  int'(bus_a.busy), 0);
      check("abort done",  int'(bus_a.done), 0);
      repeat (3) step();
      reset = 1'b0;
      repeat (250) step();
      check("abort no frame", frames[0], f0);
      check("abort no done", done_cnt[0], dn0);
      check("abort no sclk", rises[0], r0);

      // fast instance
      f0 = frames[1]; dn0 = done_cnt[1];
      set_volt(1, 8'hC3); set_start(1, 1'b1); step();
      check("fast cs_n low after accept", int'(bus_b.spi_cs_n), 0);
      set_start(1, 1'b0);
      wait_frames(1, f0 + 1, 200, "fast frame");
      check("fast frame bits", int'(last_frame[1]), 16'h3C30);
      check("fast cs_n low cycles", last_cs_low[1], 68);
      check("fast sclk period", last_period[1], 4);
      check("fast sclk rises", last_nbits[1], 16);
      wait_not_busy(1, 20, "fast busy release");
      check("fast busy cycles", last_busy[1], 69);
      check("fast done pulses", done_cnt[1], dn0 + 1);

      check("mosi stable at rise (default)", unstable[0], 0);
      check("mosi stable at rise (fast)", unstable[1], 0);
      check("done aligned to cs_n rise (default)", done_bad[0], 0);
      check("done aligned to cs_n rise (fast)", done_bad[1], 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5, meaning clk cycles per SCLK half-period (SCLK = 5 MHz at 50 MHz clk); legal range 2..255.
REQ-002 SHALL have parameter CS_GAP, default 4, meaning minimum clk cycles spi_cs_n stays high between frames.
REQ-003 SHALL have parameter DAC_CMD, default 4'h3, meaning the 4-bit command nibble sent at the head of every frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port spi_start  input  1  frame request from the voltage ramp controller; its rising edge triggers a frame.
REQ-007 SHALL have port voltage  input  8  DAC code to transmit.
REQ-008 SHALL have port spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 SHALL have port spi_mosi  output  1  serial data, MSB first.
REQ-010 SHALL have port spi_cs_n  output  1  active-low DAC chip select.
REQ-011 SHALL have port busy  output  1  high from frame acceptance to end of CS gap.
REQ-012 SHALL have port done  output  1  one-cycle pulse when spi_cs_n returns high.

Function
REQ-013 SHALL detect a start as spi_start high on this cycle and low on the previous registered sample; a level held high SHALL NOT retrigger.
REQ-014 SHALL, on an accepted start while idle, capture voltage that cycle and form frame {DAC_CMD, voltage, 4'b0000} (16 bits).
REQ-015 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-016 SETUP: spi_cs_n low, spi_sclk low, spi_mosi = frame bit 15, for CLK_DIV cycles, starting the cycle after the start edge.
REQ-017 SHIFT: spi_sclk toggles every CLK_DIV cycles, 16 rising edges; spi_mosi changes only on falling edges (next bit), stable across each rising edge.
REQ-018 HOLD: after the 16th falling edge, spi_sclk low, spi_cs_n low for CLK_DIV cycles; then spi_cs_n high and done pulsed for exactly that first high cycle.
REQ-019 GAP: spi_cs_n high, spi_sclk low, spi_mosi low for CS_GAP cycles; busy stays high; then IDLE.
REQ-020 spi_cs_n low duration SHALL be exactly 34*CLK_DIV cycles (170 at defaults); busy duration 34*CLK_DIV + CS_GAP cycles.
REQ-021 A start edge while busy SHALL latch voltage into a one-deep pending register (later edges overwrite it); on leaving GAP with pending set, SHALL go directly to SETUP with the pending value, no extra idle cycle.
REQ-022 A start edge on the same cycle GAP completes SHALL be treated as pending and served immediately.
REQ-023 Changes on voltage after capture SHALL NOT affect the frame in flight.
REQ-024 Bit counter SHALL be 5 bits, divider counter 8 bits; neither wraps within a frame.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, spi_sclk 0, spi_mosi 0, spi_cs_n 1, busy 0, done 0, pending cleared, counters 0, edge-detect register 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately; no done pulse; a spi_start already high at reset release SHALL NOT start a frame until it falls and rises again.

Structure
REQ-027 Shared package SHALL hold state encodings, the 16-bit frame width and DAC_CMD default; timing parameters stay per-instance.
REQ-028 The SCLK half-period tick generator SHALL be a sub-module sclk_divider (enable, clear, tick output).

Verification
REQ-029 Reset, spi_start rises with voltage=8'hA5 -> cs_n low next cycle, 16 bits sampled on SCLK rising = 16'h3A50, cs_n low 170 cycles, done 1 pulse, busy low 174 cycles after acceptance.
REQ-030 spi_start held high 4 cycles (controller INIT) -> exactly one frame.
REQ-031 Edges with voltage 8'h01 then 8'h02 during a frame -> second frame carries 16'h3020, starts immediately after GAP, cs_n high exactly 4 cycles between frames.
REQ-032 Reset asserted at bit 7 -> outputs at reset values same cycle, no done, no further SCLK edges.
REQ-033 voltage changed to 8'hFF mid-frame after capturing 8'h00 -> frame remains 16'h3000.
REQ-034 CLK_DIV=2, CS_GAP=1 -> cs_n low 68 cycles, SCLK period 4 cycles, MOSI stable at every rising edge.
